// File: rtl/wb_palette_ram_if.sv
// wishbone_b3: 32-bit Wishbone B3 bus with registered-feedback burst tags (cti/bte).
// Rev 1.0 - initial release
`default_nettype none

interface wishbone_b3;
  logic [31:0] adr;
  logic [31:0] dat_m2s;
  logic [31:0] dat_s2m;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;
  logic        rty;

  modport slave (
    input  adr, dat_m2s, sel, we, cyc, stb, cti, bte,
    output dat_s2m, ack, err, rty
  );

  modport master (
    output adr, dat_m2s, sel, we, cyc, stb, cti, bte,
    input  dat_s2m, ack, err, rty
  );
endinterface

`default_nettype wire

// File: rtl/wb_palette_ram.sv
// wb_palette_ram: Wishbone B3 colour palette RAM with a 2-stage pixel lookup port.
// Rev 1.0 - initial release
`default_nettype none

module wb_palette_ram #(
  parameter int INDEX_BITS = 8,
  parameter int PAL_BITS   = 2,
  parameter int CHAN_BITS  = 8,
  parameter int ALPHA_EN   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  wishbone_b3.slave             bus,
  input  logic                  frame_start,
  input  logic [PAL_BITS-1:0]   pix_palette,
  input  logic                  pix_valid,
  input  logic [INDEX_BITS-1:0] pix_index,
  input  logic                  pix_blank,
  output logic                  out_valid,
  output logic [CHAN_BITS-1:0]  r,
  output logic [CHAN_BITS-1:0]  g,
  output logic [CHAN_BITS-1:0]  b,
  output logic [7:0]            a
);

  localparam int AW    = PAL_BITS + INDEX_BITS;
  localparam int DEPTH = 1 << AW;

  // Channels are MSB-aligned within their byte lane; alpha owns lane 0 when enabled.
  localparam logic [7:0]  c_CMASK = 8'hFF << (8 - CHAN_BITS);
  localparam logic [7:0]  c_AMASK = (ALPHA_EN != 0) ? 8'hFF : 8'h00;
  localparam logic [31:0] c_WMASK = {c_CMASK, c_CMASK, c_CMASK, c_AMASK};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         mem_q [DEPTH];
  logic [31:0]         rd_data_q;
  logic [31:0]         pix_data_q;
  logic [AW-1:0]       rd_addr;
  logic [PAL_BITS-1:0] shadow_q;
  logic                v1_q, blank1_q, out_valid_q;
  logic [CHAN_BITS-1:0] r_q, g_q, b_q;
  logic [7:0]          a_q;

  logic [AW-1:0]       w_badr;
  logic [AW-1:0]       w_pix_addr;
  logic [PAL_BITS-1:0] w_pal;
  logic                w_ack, w_wr, w_burst;
  logic                w_unused;

  assign w_badr   = bus.adr[AW+1:2];
  assign w_ack    = (state_q == ST_ACK);
  assign w_wr     = w_ack & bus.cyc & bus.stb & bus.we;
  assign w_burst  = bus.cyc & bus.stb & (bus.cti == 3'b010) & (bus.bte == 2'b00);
  // A pixel in the frame_start cycle already sees the newly requested palette.
  assign w_pal      = frame_start ? pix_palette : shadow_q;
  assign w_pix_addr = {w_pal, pix_index};

  assign bus.ack     = w_ack;
  assign bus.err     = 1'b0;
  assign bus.rty     = 1'b0;
  assign bus.dat_s2m = rd_data_q & c_WMASK;

  always_comb begin
    state_d = state_q;
    rd_addr = w_badr;
    unique case (state_q)
      ST_IDLE: if (bus.cyc && bus.stb) state_d = ST_ACK;
      ST_ACK: begin
        if (w_burst) begin
          state_d = ST_ACK;
          rd_addr = w_badr + AW'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Both read ports sample the old word when a write to the same address commits.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int l = 0; l < 4; l++) begin
        if (bus.sel[l]) mem_q[w_badr][l*8 +: 8] <= bus.dat_m2s[l*8 +: 8] & c_WMASK[l*8 +: 8];
      end
    end
    rd_data_q  <= mem_q[rd_addr];
    pix_data_q <= mem_q[w_pix_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q    <= '0;
      v1_q        <= 1'b0;
      blank1_q    <= 1'b0;
      out_valid_q <= 1'b0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      a_q         <= '0;
    end else begin
      if (frame_start) shadow_q <= pix_palette;
      v1_q        <= pix_valid;
      blank1_q    <= pix_blank;
      out_valid_q <= v1_q;
      if (v1_q) begin
        r_q <= blank1_q ? '0 : pix_data_q[31 -: CHAN_BITS];
        g_q <= blank1_q ? '0 : pix_data_q[23 -: CHAN_BITS];
        b_q <= blank1_q ? '0 : pix_data_q[15 -: CHAN_BITS];
        a_q <= (blank1_q || ALPHA_EN == 0) ? 8'h00 : pix_data_q[7:0];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign r = r_q;
  assign g = g_q;
  assign b = b_q;
  assign a = a_q;

  assign w_unused = ^{bus.adr[31:AW+2], bus.adr[1:0], pix_data_q};

endmodule

`default_nettype wire

// File: tb/tb_wb_palette_ram.sv
// tb_wb_palette_ram: scoreboard bench for two palette RAM variants (8-bit no alpha, 4-bit with alpha).
// Rev 1.0 - initial release
`default_nettype none

module tb_wb_palette_ram;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wishbone_b3 wb();
  wishbone_b3 wb4();

  logic       frame_start, pix_valid, pix_blank;
  logic [1:0] pix_palette;
  logic [7:0] pix_index;
  logic       out_valid, out_valid4;
  logic [7:0] r, g, b, a, a4;
  logic [3:0] r4, g4, b4;

  assign wb4.adr     = wb.adr;
  assign wb4.dat_m2s = wb.dat_m2s;
  assign wb4.sel     = wb.sel;
  assign wb4.we      = wb.we;
  assign wb4.cyc     = wb.cyc;
  assign wb4.stb     = wb.stb;
  assign wb4.cti     = wb.cti;
  assign wb4.bte     = wb.bte;

  wb_palette_ram #(.INDEX_BITS(8), .PAL_BITS(2), .CHAN_BITS(8), .ALPHA_EN(0)) u_dut (
    .clk(clk), .rst(rst), .bus(wb),
    .frame_start(frame_start), .pix_palette(pix_palette), .pix_valid(pix_valid),
    .pix_index(pix_index), .pix_blank(pix_blank),
    .out_valid(out_valid), .r(r), .g(g), .b(b), .a(a)
  );

  wb_palette_ram #(.INDEX_BITS(8), .PAL_BITS(2), .CHAN_BITS(4), .ALPHA_EN(1)) u_dut4 (
    .clk(clk), .rst(rst), .bus(wb4),
    .frame_start(frame_start), .pix_palette(pix_palette), .pix_valid(pix_valid),
    .pix_index(pix_index), .pix_blank(pix_blank),
    .out_valid(out_valid4), .r(r4), .g(g4), .b(b4), .a(a4)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mdl  [1024];
  logic [31:0] mdl4 [1024];
  logic [31:0] m8 = 32'hFFFFFF00;
  logic [31:0] m4 = 32'hF0F0F0FF;
  logic [1:0]  sh;

  logic [31:0] q_bus[$], q_bus4[$], q_pix[$];
  logic [19:0] q_pix4[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic mwrite(input logic [9:0] word, input logic [31:0] d, input logic [3:0] s);
    for (int l = 0; l < 4; l++) begin
      if (s[l]) begin
        mdl[word][l*8 +: 8]  = d[l*8 +: 8] & m8[l*8 +: 8];
        mdl4[word][l*8 +: 8] = d[l*8 +: 8] & m4[l*8 +: 8];
      end
    end
  endtask

  task automatic pix_drive(input logic fs, input logic [1:0] pal, input logic [7:0] idx, input logic blank);
    logic [31:0] w, w4;
    frame_start = fs;
    pix_palette = pal;
    pix_valid   = 1'b1;
    pix_index   = idx;
    pix_blank   = blank;
    if (fs) sh = pal;
    w  = mdl[{sh, idx}];
    w4 = mdl4[{sh, idx}];
    q_pix.push_back(blank ? 32'h0 : {w[31:8], 8'h00});
    q_pix4.push_back(blank ? 20'h0 : {w4[31:28], w4[23:20], w4[15:12], w4[7:0]});
  endtask

  task automatic pixel(input logic fs, input logic [1:0] pal, input logic [7:0] idx, input logic blank);
    @(posedge clk); #1;
    pix_drive(fs, pal, idx, blank);
    @(posedge clk); #1;
    frame_start = 1'b0; pix_valid = 1'b0; pix_blank = 1'b0;
    @(negedge clk); check("pix_lat1", {31'b0, out_valid}, 32'd0);
    @(negedge clk); check("pix_lat2", {31'b0, out_valid}, 32'd1);
  endtask

  task automatic wb_classic(input logic w, input logic [9:0] word, input logic [31:0] d,
                            input logic [3:0] s, input logic collide);
    @(posedge clk); #1;
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = w; wb.adr = {20'b0, word, 2'b00};
    wb.dat_m2s = d; wb.sel = s; wb.cti = 3'b000; wb.bte = 2'b00;
    if (!w) begin
      q_bus.push_back(mdl[word]);
      q_bus4.push_back(mdl4[word]);
    end
    @(negedge clk); check("classic_ws", {31'b0, wb.ack}, 32'd0);
    @(posedge clk); #1;
    if (collide) pix_drive(1'b0, 2'd0, word[7:0], 1'b0);
    @(negedge clk); check("classic_ack", {31'b0, wb.ack}, 32'd1);
    @(posedge clk); #1;
    if (w) mwrite(word, d, s);
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0; pix_valid = 1'b0;
    @(negedge clk); check("classic_end", {31'b0, wb.ack}, 32'd0);
  endtask

  task automatic burst_beat(input logic [9:0] base, input int i, input int n);
    logic [9:0] wd;
    wd = base + 10'(i);
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.adr = {20'b0, wd, 2'b00};
    wb.sel = 4'hF; wb.bte = 2'b00; wb.cti = (i == n - 1) ? 3'b111 : 3'b010;
    q_bus.push_back(mdl[wd]);
    q_bus4.push_back(mdl4[wd]);
  endtask

  task automatic wb_burst(input logic [9:0] base, input int n, input logic rst_mid);
    @(posedge clk); #1;
    burst_beat(base, 0, n);
    @(negedge clk); check("burst_ws", {31'b0, wb.ack}, 32'd0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); check("burst_ack", {31'b0, wb.ack}, 32'd1);
      if (rst_mid) begin
        #2 rst = 1'b1;
        #1 check("rst_ack_async", {31'b0, wb.ack}, 32'd0);
        wb.cyc = 1'b0; wb.stb = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (i < n - 1) burst_beat(base, i + 1, n);
      else begin wb.cyc = 1'b0; wb.stb = 1'b0; wb.cti = 3'b000; end
    end
    @(negedge clk); check("burst_end", {31'b0, wb.ack}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && wb.ack && wb.cyc && wb.stb && !wb.we) begin
      if (q_bus.size() == 0) check("bus_unexpected_ack", {31'b0, wb.ack}, 32'd0);
      else begin
        check("bus_rd", wb.dat_s2m, q_bus.pop_front());
        check("bus_rd4", wb4.dat_s2m, q_bus4.pop_front());
      end
    end
    if (!rst && out_valid) begin
      if (q_pix.size() == 0) check("pix_unexpected", {31'b0, out_valid}, 32'd0);
      else check("pix_rgba", {r, g, b, a}, q_pix.pop_front());
    end
    if (!rst && out_valid4) begin
      if (q_pix4.size() == 0) check("pix4_unexpected", {31'b0, out_valid4}, 32'd0);
      else check("pix4_rgba", {12'b0, r4, g4, b4, a4}, {12'b0, q_pix4.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no summary expected one");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; sh = 2'd0;
    wb.adr = '0; wb.dat_m2s = '0; wb.sel = '0; wb.we = 1'b0;
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.cti = '0; wb.bte = '0;
    frame_start = 1'b0; pix_palette = '0; pix_valid = 1'b0; pix_index = '0; pix_blank = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ack", {31'b0, wb.ack}, 32'd0);
    check("rst_err_rty", {30'b0, wb.err, wb.rty}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_rgba", {r, g, b, a}, 32'd0);

    // Classic write / read and byte-lane writes
    wb_classic(1'b1, 10'd5, 32'hFF804000, 4'b1111, 1'b0);
    wb_classic(1'b0, 10'd5, 32'h0, 4'b1111, 1'b0);
    wb_classic(1'b1, 10'd5, 32'h00AA0000, 4'b0100, 1'b0);
    wb_classic(1'b0, 10'd5, 32'h0, 4'b1111, 1'b0);
    wb_classic(1'b1, 10'h020, 32'h12345678, 4'b1111, 1'b0);
    wb_classic(1'b0, 10'h020, 32'h0, 4'b1111, 1'b0);

    // Wrapping incrementing burst
    wb_classic(1'b1, 10'h3FE, 32'hA1A2A3A4, 4'b1111, 1'b0);
    wb_classic(1'b1, 10'h3FF, 32'hB1B2B3B4, 4'b1111, 1'b0);
    wb_classic(1'b1, 10'h000, 32'hC1C2C3C4, 4'b1111, 1'b0);
    wb_classic(1'b1, 10'h001, 32'hD1D2D3D4, 4'b1111, 1'b0);
    wb_burst(10'h3FE, 4, 1'b0);

    // Read-first collision on palette 0 index 9
    wb_classic(1'b1, 10'd9, 32'hAABBCC00, 4'b1111, 1'b0);
    wb_classic(1'b1, 10'd9, 32'h01020300, 4'b1111, 1'b1);
    pixel(1'b0, 2'd0, 8'd9, 1'b0);

    // Frame-synchronous palette switch, blanking, shadow persistence
    wb_classic(1'b1, 10'h207, 32'h11223300, 4'b1111, 1'b0);
    wb_classic(1'b1, 10'h007, 32'h00000000, 4'b1111, 1'b0);
    pixel(1'b1, 2'd2, 8'd7, 1'b0);
    pixel(1'b1, 2'd2, 8'd7, 1'b1);
    pixel(1'b0, 2'd0, 8'd7, 1'b0);

    // Reset in the middle of a burst
    wb_burst(10'h3FE, 4, 1'b1);
    sh = 2'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ack", {31'b0, wb.ack}, 32'd0);
    check("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("post_rst_rgba", {r, g, b, a}, 32'd0);
    pixel(1'b0, 2'd0, 8'd7, 1'b0);
    wb_classic(1'b0, 10'h207, 32'h0, 4'b1111, 1'b0);

    repeat (3) @(posedge clk);
    check("sb_bus_drain", q_bus.size(), 32'd0);
    check("sb_pix_drain", q_pix.size(), 32'd0);
    check("sb_pix4_drain", q_pix4.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
